layer_compositor: RTL and testbench

- Parametrised pixel compositor that replaces the fixed 6-layer case-statement mux at the top level.
- Takes NUM_LAYERS sprite layers, each with an rgb value and an enable bit, and resolves them by fixed priority. Supports per-layer colour-key transparency, a frame-synchronous layer mask and a highlight colour when two chosen layers overlap.
- Counts overlap pixels per frame; game logic uses this count for collision/game-over.
- Sits between the sprite modules and the vgaR/vgaG/vgaB pins, fed by display_controller timing.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/layer_priority_mux.sv | 28 ++
 rtl/layer_compositor.sv | 130 +++++++++++++
 tb/tb_layer_compositor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pixel definitions: 4:4:4 colour width, common colours and pack/unpack helpers.
package vga_pkg;

  localparam int unsigned RGB_W = 12;
  localparam int unsigned CH_W  = 4;

  localparam logic [RGB_W-1:0] RGB_BLACK      = 12'h000;
  localparam logic [RGB_W-1:0] RGB_WHITE      = 12'hFFF;
  localparam logic [RGB_W-1:0] RGB_KEY        = 12'hF0F;
  localparam logic [RGB_W-1:0] RGB_BG_DEFAULT = 12'h69C;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb444_t;

  function automatic rgb444_t rgb_unpack(input logic [RGB_W-1:0] v);
    return rgb444_t'(v);
  endfunction

  function automatic logic [RGB_W-1:0] rgb_pack(input rgb444_t c);
    return {c.r, c.g, c.b};
  endfunction

endpackage

// File: rtl/layer_priority_mux.sv
// Fixed-priority layer select: lowest-index effective layer wins.
module layer_priority_mux #(
  parameter int unsigned NUM_LAYERS = 6,
  parameter int unsigned RGB_W      = 12
) (
  input  logic [NUM_LAYERS-1:0]       eff_i,
  input  logic [NUM_LAYERS*RGB_W-1:0] rgb_i,
  output logic [RGB_W-1:0]            win_rgb_c,
  output logic                        any_on_c
);

  logic [RGB_W-1:0] win;
  logic             found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (eff_i[i] && !found) begin
        win   = rgb_i[i*RGB_W +: RGB_W];
        found = 1'b1;
      end
    end
    win_rgb_c = win;
    any_on_c  = found;
  end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: keyed/masked layer priority, pair highlight and per-frame overlap counting.
module layer_compositor #(
  parameter int unsigned           NUM_LAYERS = 6,
  parameter int unsigned           RGB_W      = 12,
  parameter logic [RGB_W-1:0]      KEY_RGB    = vga_pkg::RGB_KEY,
  parameter logic [NUM_LAYERS-1:0] KEY_LAYERS = '0,
  parameter int unsigned           HL_A       = 0,
  parameter int unsigned           HL_B       = 4,
  parameter logic [RGB_W-1:0]      HL_RGB     = vga_pkg::RGB_WHITE,
  parameter logic [NUM_LAYERS-1:0] RESET_MASK = '1,
  parameter int unsigned           CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        bright,
  input  logic                        frame_start,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]       layer_mask_next,
  input  logic [RGB_W-1:0]            bg_rgb,
  output logic [RGB_W-1:0]            rgb_out,
  output logic                        bright_out,
  output logic                        collision,
  output logic [CNT_W-1:0]            collision_count
);

  import vga_pkg::*;

  localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic [NUM_LAYERS-1:0]       mask_q;
  logic [NUM_LAYERS-1:0]       mask_c;
  logic [NUM_LAYERS-1:0]       eff_c;
  logic [NUM_LAYERS-1:0]       eff_s1_q;
  logic [NUM_LAYERS*RGB_W-1:0] rgb_s1_q;
  logic [RGB_W-1:0]            bg_s1_q;
  logic                        bright_s1_q;
  logic                        fs_s1_q;

  logic [RGB_W-1:0] win_rgb_c;
  logic             any_on_c;
  logic             hl_c;
  logic             overlap_c;
  logic [RGB_W-1:0] pix_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_d;
  logic             coll_d;

  // The frame_start pixel already sees the new mask, so the whole frame is consistent.
  assign mask_c = frame_start ? layer_mask_next : mask_q;

  always_comb begin
    eff_c = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      eff_c[i] = layer_en[i] & mask_c[i]
               & ~(KEY_LAYERS[i] & (layer_rgb[i*RGB_W +: RGB_W] == KEY_RGB));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q      <= RESET_MASK;
      eff_s1_q    <= '0;
      rgb_s1_q    <= '0;
      bg_s1_q     <= '0;
      bright_s1_q <= 1'b0;
      fs_s1_q     <= 1'b0;
    end else begin
      mask_q      <= mask_c;
      eff_s1_q    <= eff_c;
      rgb_s1_q    <= layer_rgb;
      bg_s1_q     <= bg_rgb;
      bright_s1_q <= bright;
      fs_s1_q     <= frame_start;
    end
  end

  layer_priority_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .RGB_W      (RGB_W)
  ) u_mux (
    .eff_i     (eff_s1_q),
    .rgb_i     (rgb_s1_q),
    .win_rgb_c (win_rgb_c),
    .any_on_c  (any_on_c)
  );

  assign hl_c      = eff_s1_q[IDX_W'(HL_A)] & eff_s1_q[IDX_W'(HL_B)];
  assign overlap_c = bright_s1_q & hl_c;

  always_comb begin
    pix_d = RGB_W'(RGB_BLACK);
    if (bright_s1_q) begin
      if (hl_c)          pix_d = HL_RGB;
      else if (any_on_c) pix_d = win_rgb_c;
      else               pix_d = bg_s1_q;
    end
  end

  // Boundary pixel is excluded from the closing frame and seeds the next one.
  always_comb begin
    acc_d   = acc_q;
    count_d = collision_count;
    coll_d  = collision;
    if (fs_s1_q) begin
      count_d = acc_q;
      coll_d  = (acc_q != '0);
      acc_d   = CNT_W'(overlap_c);
    end else if (overlap_c && (acc_q != '1)) begin
      acc_d = acc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_out         <= '0;
      bright_out      <= 1'b0;
      collision       <= 1'b0;
      collision_count <= '0;
      acc_q           <= '0;
    end else begin
      rgb_out         <= pix_d;
      bright_out      <= bright_s1_q;
      collision       <= coll_d;
      collision_count <= count_d;
      acc_q           <= acc_d;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: per-cycle reference model check plus literal expectations.
module tb_layer_compositor;

  localparam int NL = 6;
  localparam int RW = 12;
  localparam logic [NL-1:0] KEY_L = 6'b000100;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              bright = 1'b0;
  logic              frame_start = 1'b0;
  logic [NL-1:0]     layer_en = '0;
  logic [NL*RW-1:0]  layer_rgb = '0;
  logic [NL-1:0]     layer_mask_next = 6'h3F;
  logic [RW-1:0]     bg_rgb = 12'h69C;

  logic [RW-1:0] rgb_out, rgb_out_s;
  logic          bright_out, bright_out_s;
  logic          collision, collision_s;
  logic [15:0]   collision_count;
  logic [3:0]    collision_count_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  layer_compositor #(.KEY_LAYERS(KEY_L)) dut (
    .clk(clk), .reset(reset), .bright(bright), .frame_start(frame_start),
    .layer_en(layer_en), .layer_rgb(layer_rgb), .layer_mask_next(layer_mask_next),
    .bg_rgb(bg_rgb), .rgb_out(rgb_out), .bright_out(bright_out),
    .collision(collision), .collision_count(collision_count)
  );

  layer_compositor #(.KEY_LAYERS(KEY_L), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .bright(bright), .frame_start(frame_start),
    .layer_en(layer_en), .layer_rgb(layer_rgb), .layer_mask_next(layer_mask_next),
    .bg_rgb(bg_rgb), .rgb_out(rgb_out_s), .bright_out(bright_out_s),
    .collision(collision_s), .collision_count(collision_count_s)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference pixel: what the screen must show for one set of inputs.
  function automatic logic [RW-1:0] model_pix(input logic [NL-1:0] en, input logic [NL*RW-1:0] rgb,
                                              input logic [NL-1:0] m, input logic [RW-1:0] bg,
                                              input logic br, output logic ov);
    logic [NL-1:0] e;
    for (int i = 0; i < NL; i++)
      e[i] = en[i] && m[i] && !(KEY_L[i] && rgb[i*RW +: RW] == 12'hF0F);
    ov = br && e[0] && e[4];
    if (!br) return 12'h000;
    if (e[0] && e[4]) return 12'hFFF;
    for (int i = 0; i < NL; i++)
      if (e[i]) return rgb[i*RW +: RW];
    return bg;
  endfunction

  logic [NL-1:0] m_mask;
  logic [RW-1:0] p_rgb, e_rgb;
  logic          p_ov, p_fs, p_br, e_br, e_coll;
  int            acc16, acc4, cnt16, cnt4;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mask = 6'h3F;
      p_rgb = '0; p_ov = 0; p_fs = 0; p_br = 0;
      e_rgb = '0; e_br = 0; e_coll = 0;
      acc16 = 0; acc4 = 0; cnt16 = 0; cnt4 = 0;
    end else begin
      e_rgb = p_rgb;
      e_br  = p_br;
      if (p_fs) begin
        cnt16 = acc16; cnt4 = acc4; e_coll = (acc16 != 0);
        acc16 = int'(p_ov); acc4 = int'(p_ov);
      end else if (p_ov) begin
        if (acc16 < 65535) acc16++;
        if (acc4 < 15) acc4++;
      end
      if (frame_start) m_mask = layer_mask_next;
      p_rgb = model_pix(layer_en, layer_rgb, m_mask, bg_rgb, bright, p_ov);
      p_fs  = frame_start;
      p_br  = bright;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
      chk("bright_out", 32'(bright_out), 32'(e_br));
      chk("collision", 32'(collision), 32'(e_coll));
      chk("collision_count", 32'(collision_count), 32'(cnt16));
      chk("rgb_out_s", 32'(rgb_out_s), 32'(e_rgb));
      chk("collision_s", 32'(collision_s), 32'(e_coll));
      chk("collision_count_s", 32'(collision_count_s), 32'(cnt4));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rgb(input int idx, input logic [RW-1:0] v);
    layer_rgb[idx*RW +: RW] = v;
  endtask

  task automatic drive(input logic [NL-1:0] en, input logic br, input logic fs);
    layer_en = en; bright = br; frame_start = fs;
  endtask

  task automatic close_frame();
    drive(6'b000000, 1'b1, 1'b1); tick();
    drive(6'b000000, 1'b1, 1'b0); tick();
  endtask

  initial begin
    set_rgb(0, 12'h00A); set_rgb(1, 12'h0F0); set_rgb(2, 12'hF0F);
    set_rgb(3, 12'h333); set_rgb(4, 12'hF00); set_rgb(5, 12'h555);
    repeat (3) tick();
    chk("reset rgb_out", 32'(rgb_out), 32'h0);
    chk("reset bright_out", 32'(bright_out), 32'h0);
    chk("reset collision", 32'(collision), 32'h0);
    chk("reset count", 32'(collision_count), 32'h0);
    reset = 1'b1;
    drive(6'b000000, 1'b1, 1'b0); tick();

    close_frame();
    chk("first boundary count", 32'(collision_count), 32'h0);
    chk("idle bg", 32'(rgb_out), 32'h69C);

    drive(6'b010010, 1'b1, 1'b0); tick();
    drive(6'b000000, 1'b1, 1'b0); tick();
    chk("priority rgb", 32'(rgb_out), 32'h0F0);
    chk("priority bright", 32'(bright_out), 32'h1);

    drive(6'b000100, 1'b1, 1'b0); tick();
    drive(6'b000000, 1'b1, 1'b0); tick();
    chk("key to bg", 32'(rgb_out), 32'h69C);
    set_rgb(2, 12'h00F);
    drive(6'b000100, 1'b1, 1'b0); tick();
    drive(6'b000000, 1'b1, 1'b0); tick();
    chk("non-key colour", 32'(rgb_out), 32'h00F);

    drive(6'b010001, 1'b1, 1'b0); tick();
    drive(6'b010001, 1'b0, 1'b0); tick();
    chk("highlight", 32'(rgb_out), 32'hFFF);
    drive(6'b000000, 1'b1, 1'b0); tick();
    chk("blank rgb", 32'(rgb_out), 32'h0);
    chk("blank bright", 32'(bright_out), 32'h0);
    close_frame();
    chk("one overlap count", 32'(collision_count), 32'h1);
    chk("one overlap flag", 32'(collision), 32'h1);

    repeat (37) begin drive(6'b010001, 1'b1, 1'b0); tick(); end
    repeat (3) begin drive(6'b000001, 1'b1, 1'b0); tick(); end
    close_frame();
    chk("count 37", 32'(collision_count), 32'd37);
    chk("collision 37", 32'(collision), 32'h1);
    chk("count 37 sat", 32'(collision_count_s), 32'd15);
    repeat (10) tick();
    chk("count held", 32'(collision_count), 32'd37);
    close_frame();
    chk("empty frame count", 32'(collision_count), 32'd0);
    chk("empty frame flag", 32'(collision), 32'h0);

    repeat (20) begin drive(6'b010001, 1'b1, 1'b0); tick(); end
    close_frame();
    chk("count 20", 32'(collision_count), 32'd20);
    chk("count 20 sat", 32'(collision_count_s), 32'd15);

    layer_mask_next = 6'b111110;
    drive(6'b000011, 1'b1, 1'b0); tick();
    drive(6'b000000, 1'b1, 1'b0); tick();
    chk("mask mid-frame ignored", 32'(rgb_out), 32'h00A);
    drive(6'b000011, 1'b1, 1'b1); tick();
    drive(6'b000001, 1'b1, 1'b0); tick();
    chk("mask on fs pixel", 32'(rgb_out), 32'h0F0);
    drive(6'b010001, 1'b1, 1'b0); tick();
    chk("masked layer0 to bg", 32'(rgb_out), 32'h69C);
    drive(6'b000000, 1'b1, 1'b0); tick();
    chk("masked pair no hl", 32'(rgb_out), 32'hF00);
    layer_mask_next = 6'h3F;
    close_frame();
    chk("masked frame count", 32'(collision_count), 32'd0);

    drive(6'b010001, 1'b1, 1'b1); tick();
    drive(6'b010001, 1'b1, 1'b1); tick();
    drive(6'b000000, 1'b1, 1'b1); tick();
    chk("b2b 1-pixel frame", 32'(collision_count), 32'd1);
    drive(6'b000000, 1'b1, 1'b0); tick();
    chk("b2b second", 32'(collision_count), 32'd1);
    chk("b2b flag", 32'(collision), 32'h1);
    tick();
    close_frame();
    chk("b2b after", 32'(collision_count), 32'd0);

    repeat (5) begin drive(6'b010001, 1'b1, 1'b0); tick(); end
    close_frame();
    chk("pre-reset count", 32'(collision_count), 32'd5);
    repeat (3) begin drive(6'b010001, 1'b1, 1'b0); tick(); end
    reset = 1'b0;
    #1;
    chk("async reset rgb", 32'(rgb_out), 32'h0);
    chk("async reset bright", 32'(bright_out), 32'h0);
    chk("async reset flag", 32'(collision), 32'h0);
    chk("async reset count", 32'(collision_count), 32'h0);
    chk("async reset count_s", 32'(collision_count_s), 32'h0);
    tick();
    reset = 1'b1;
    repeat (2) begin drive(6'b010001, 1'b1, 1'b0); tick(); end
    close_frame();
    chk("post-reset boundary", 32'(collision_count), 32'd2);
    close_frame();
    chk("post-reset empty", 32'(collision_count), 32'd0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
